// File: rtl/disp_page_sched.sv
// Display page scheduler: manual, auto-scroll and activity jump-and-hold page selection.
// Optional display blank pulse on page change is enabled by defining DISP_PAGE_BLANK_EN.
module disp_page_sched #(
    parameter int WIDTH     = 16,
    parameter int DWELL     = 50000000,
    parameter int HOLD      = 100000000,
    parameter int BLANK_CYC = 5000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode_auto,
    input  logic [1:0]           sel,
    input  logic [3:0]           act,
    input  logic [4*WIDTH-1:0]   data_bank,
    output logic [WIDTH-1:0]     data_out,
    output logic [1:0]           page,
    output logic [3:0]           page_onehot,
    output logic                 in_hold,
    output logic                 blank
);

    localparam int DW = $clog2(DWELL);
    localparam int HW = $clog2(HOLD);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD - 1);

    typedef enum logic [1:0] {
        S_MANUAL = 2'd0,
        S_AUTO   = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t                 state;
    logic [DW-1:0]          dwell_cnt;
    logic [HW-1:0]          hold_cnt;
    logic [1:0]             page_nxt;
    logic [3:0][WIDTH-1:0]  bank_pg;
    logic                   any_act;
    logic                   dwell_last;
    logic                   hold_last;

    assign bank_pg    = data_bank;
    assign any_act    = |act;
    assign dwell_last = (dwell_cnt == DWELL_LAST);
    assign hold_last  = (hold_cnt == HOLD_LAST);

    // act[0] has the highest priority
    function automatic logic [1:0] winner(input logic [3:0] a);
        if (a[0])      return 2'd0;
        else if (a[1]) return 2'd1;
        else if (a[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    function automatic logic [3:0] decode(input logic [1:0] p);
        return 4'b0001 << p;
    endfunction

    always_comb begin
        page_nxt = page;
        case (state)
            S_MANUAL: begin
                if (any_act)         page_nxt = winner(act);
                else if (!mode_auto) page_nxt = sel;
            end
            S_AUTO: begin
                if (any_act)         page_nxt = winner(act);
                else if (!mode_auto) page_nxt = sel;
                else if (dwell_last) page_nxt = page + 2'd1;
            end
            S_HOLD: begin
                if (any_act)                     page_nxt = winner(act);
                else if (hold_last && !mode_auto) page_nxt = sel;
            end
            default: page_nxt = page;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_MANUAL;
            page        <= 2'd0;
            page_onehot <= 4'b0001;
            data_out    <= '0;
            in_hold     <= 1'b0;
            dwell_cnt   <= '0;
            hold_cnt    <= '0;
        end else begin
            page        <= page_nxt;
            page_onehot <= decode(page_nxt);
            data_out    <= bank_pg[page];
            case (state)
                S_MANUAL: begin
                    dwell_cnt <= '0;
                    if (any_act) begin
                        state    <= S_HOLD;
                        hold_cnt <= '0;
                        in_hold  <= 1'b1;
                    end else if (mode_auto) begin
                        state <= S_AUTO;
                    end
                end
                S_AUTO: begin
                    if (any_act) begin
                        state     <= S_HOLD;
                        hold_cnt  <= '0;
                        dwell_cnt <= '0;
                        in_hold   <= 1'b1;
                    end else if (!mode_auto) begin
                        state     <= S_MANUAL;
                        dwell_cnt <= '0;
                    end else if (dwell_last) begin
                        dwell_cnt <= '0;
                    end else begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (any_act) begin
                        hold_cnt <= '0;
                    end else if (hold_last) begin
                        state     <= mode_auto ? S_AUTO : S_MANUAL;
                        hold_cnt  <= '0;
                        dwell_cnt <= '0;
                        in_hold   <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= S_MANUAL;
                    in_hold   <= 1'b0;
                    dwell_cnt <= '0;
                    hold_cnt  <= '0;
                end
            endcase
        end
    end

`ifdef DISP_PAGE_BLANK_EN
    localparam int BW = $clog2(BLANK_CYC + 1);
    localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYC - 1);

    logic [BW-1:0] blank_cnt;
    logic          blank_q;

    // keyed on page_nxt so the pulse starts on the same edge the page moves
    always_ff @(posedge clk) begin
        if (rst) begin
            blank_q   <= 1'b0;
            blank_cnt <= '0;
        end else if (page_nxt != page) begin
            blank_q   <= 1'b1;
            blank_cnt <= BLANK_LOAD;
        end else if (blank_cnt != '0) begin
            blank_cnt <= blank_cnt - 1'b1;
        end else begin
            blank_q <= 1'b0;
        end
    end

    assign blank = blank_q;
`else
    assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_disp_page_sched.sv
// Scoreboard bench for disp_page_sched: directed per-cycle vectors with hand-computed pages.
module tb_disp_page_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode_auto;
    logic [1:0]  sel;
    logic [3:0]  act;
    logic [63:0] data_bank;
    logic [15:0] data_out;
    logic [1:0]  page;
    logic [3:0]  page_onehot;
    logic        in_hold;
    logic        blank;

    always #5 clk = ~clk;

    disp_page_sched #(.WIDTH(16), .DWELL(4), .HOLD(6), .BLANK_CYC(3)) dut (
        .clk(clk), .rst(rst), .mode_auto(mode_auto), .sel(sel), .act(act),
        .data_bank(data_bank), .data_out(data_out), .page(page),
        .page_onehot(page_onehot), .in_hold(in_hold), .blank(blank)
    );

    typedef struct {
        logic [1:0]  pg;
        logic        hd;
        logic [15:0] dout;
        logic        bl;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] pages[4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic [1:0]  prev_pg = 2'd0;
    int          bcnt = 0;
    logic        bexp = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // one clock of stimulus; expectation is for the outputs after the coming edge
    task automatic cyc(input logic r, input logic ma, input logic [1:0] s, input logic [3:0] a,
                       input logic [1:0] ep, input logic eh);
        exp_t e;
        rst = r; mode_auto = ma; sel = s; act = a;
        e.pg   = ep;
        e.hd   = eh;
        e.dout = r ? 16'h0 : pages[prev_pg];
`ifdef DISP_PAGE_BLANK_EN
        if (r) begin
            bexp = 1'b0; bcnt = 0;
        end else if (ep != prev_pg) begin
            bexp = 1'b1; bcnt = 2;
        end else if (bcnt != 0) begin
            bcnt--;
        end else begin
            bexp = 1'b0;
        end
`else
        bexp = 1'b0;
`endif
        e.bl = bexp;
        q.push_back(e);
        prev_pg = ep;
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        logic [3:0] oh;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e  = q.pop_front();
                oh = 4'b0001 << e.pg;
                chk("page", 32'(page), 32'(e.pg));
                chk("page_onehot", 32'(page_onehot), 32'(oh));
                chk("in_hold", 32'(in_hold), 32'(e.hd));
                chk("data_out", 32'(data_out), 32'(e.dout));
                chk("blank", 32'(blank), 32'(e.bl));
            end
        end
    end

    initial begin : driver
        data_bank = 64'h4444_3333_2222_1111;
        // reset dominates act and mode_auto
        repeat (2) cyc(1, 1, 0, 4'hF, 0, 0);
        // manual select
        cyc(0, 0, 2, 0, 2, 0);
        cyc(0, 0, 3, 0, 3, 0);
        repeat (3) cyc(0, 0, 3, 0, 3, 0);
        cyc(0, 0, 0, 0, 0, 0);
        // auto-scroll from page 0 with wrap
        for (int i = 0; i < 17; i++) cyc(0, 1, 0, 0, 2'((i / 4) % 4), 0);
        cyc(0, 0, 1, 0, 1, 0);
        // activity coincident with dwell expiry wins
        repeat (4) cyc(0, 1, 1, 0, 1, 0);
        cyc(0, 1, 1, 4'b1010, 1, 1);
        repeat (5) cyc(0, 1, 1, 0, 1, 1);
        repeat (4) cyc(0, 1, 1, 0, 1, 0);
        cyc(0, 1, 1, 0, 2, 0);
        // hold ignores mode/sel, retrigger at hold_cnt=4 switches page
        cyc(0, 1, 0, 4'b0001, 0, 1);
        repeat (2) cyc(0, 0, 3, 0, 0, 1);
        repeat (2) cyc(0, 1, 0, 0, 0, 1);
        cyc(0, 1, 0, 4'b0100, 2, 1);
        repeat (5) cyc(0, 1, 0, 0, 2, 1);
        cyc(0, 1, 0, 0, 2, 0);
        // reset mid-hold at hold_cnt=3
        cyc(0, 1, 0, 4'b1000, 3, 1);
        repeat (3) cyc(0, 1, 0, 0, 3, 1);
        cyc(1, 1, 0, 4'b0010, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        // manual -> hold -> manual picks sel on the exit edge
        cyc(0, 0, 0, 4'b0100, 2, 1);
        repeat (5) cyc(0, 0, 3, 0, 2, 1);
        cyc(0, 0, 3, 0, 3, 0);
        cyc(0, 0, 3, 0, 3, 0);
        @(posedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
